// File: rtl/rv32e_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory.
// The slave view is the arbiter; the master view is the core plus memory side that drives it.
interface rv32e_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, err,
               m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, err,
               m_req, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Fetch/data arbiter onto one single-ported memory bus: data-first priority with a
// fetch anti-starvation streak limit, and a watchdog that aborts unacknowledged requests.
module rv32e_mem_arbiter #(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    rv32e_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  timer_q;
    logic        grant_d, grant_i;
    logic        m_req_q, m_we_q;
    logic [31:0] m_addr_q, m_wdata_q;
    logic [3:0]  m_wstrb_q;
    logic        i_ready_q, d_ready_q, err_q;
    logic [31:0] i_rdata_q, d_rdata_q;

    // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
    always_comb begin
        grant_d  = bus.d_req && !(bus.i_req && streak_q == STREAK_MAX);
        grant_i  = bus.i_req && !grant_d;
        streak_d = '0;
        if (grant_d && bus.i_req)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            timer_q   <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (grant_d || grant_i) begin
                        streak_q  <= streak_d;
                        m_req_q   <= 1'b1;
                        m_we_q    <= grant_d && bus.d_we;
                        m_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        m_wdata_q <= grant_d ? bus.d_wdata : '0;
                        m_wstrb_q <= (grant_d && bus.d_we) ? bus.d_wstrb : 4'b0000;
                        state_q   <= grant_d ? BUSY_D : BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // An ack on the final watchdog count still completes normally.
                    if (bus.m_ack || timer_q == TMO_LAST) begin
                        m_req_q <= 1'b0;
                        timer_q <= '0;
                        err_q   <= !bus.m_ack;
                        state_q <= IDLE;
                        if (state_q == BUSY_I) begin
                            i_ready_q <= 1'b1;
                            i_rdata_q <= bus.m_ack ? bus.m_rdata : '0;
                        end else begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= bus.m_ack ? bus.m_rdata : '0;
                        end
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.i_ready = i_ready_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Bench for rv32e_mem_arbiter: directed scenarios plus a randomized phase, all checked
// cycle by cycle against a transaction-level model of grants, completions and aborts.
module tb_rv32e_mem_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32e_mem_arbiter_if bus();
    rv32e_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // core-side request state
    logic        i_act, d_act, d_we;
    logic [31:0] i_a, d_a, d_wd;
    logic [3:0]  d_ws;
    int          i_left, d_left, i_p, d_p;
    // memory-side state
    logic        m_ack, prev_mreq, spur;
    logic [31:0] m_rd, fix_rd;
    int          mem_w, mem_delay, fixed_delay, run, last_len;
    // inputs as seen by the DUT at the last edge
    logic        p_ireq, p_dreq, p_dwe, p_ack;
    logic [31:0] p_iaddr, p_daddr, p_dwd, p_rd;
    logic [3:0]  p_dws;
    // reference model
    int          mb, mcnt, streak;
    logic        e_we, dwin;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_ws;
    // observation log
    int          tickno, last_ir_tick, last_dr_tick;
    logic        last_err_i, last_err_d;
    logic [31:0] last_irdata;
    byte         ord[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (tick %0d)", tag, obs, exp, tickno);
        end
    endtask

    task automatic drive();
        bus.i_req = i_act; bus.i_addr = i_a;
        bus.d_req = d_act; bus.d_we = d_we; bus.d_addr = d_a; bus.d_wdata = d_wd; bus.d_wstrb = d_ws;
        bus.m_ack = m_ack; bus.m_rdata = m_rd;
        p_ireq = i_act; p_iaddr = i_a; p_dreq = d_act; p_dwe = d_we;
        p_daddr = d_a; p_dwd = d_wd; p_dws = d_ws; p_ack = m_ack; p_rd = m_rd;
    endtask

    task automatic model_reset();
        mb = 0; mcnt = 0; streak = 0;
        i_act = 0; d_act = 0; d_we = 0; i_a = 0; d_a = 0; d_wd = 0; d_ws = 0;
        m_ack = 0; m_rd = 0; prev_mreq = 0; mem_w = 0; run = 0;
        drive();
    endtask

    task automatic tick();
        logic ei, ed, ee;
        logic [31:0] eir, edr;
        int dly;
        @(negedge clk);
        tickno++;
        ei = 0; ed = 0; ee = 0; eir = 0; edr = 0;
        if (mb != 0) begin
            if (p_ack || mcnt == TMO - 1) begin
                ee = !p_ack;
                if (mb == 1) begin ei = 1; eir = p_ack ? p_rd : 32'h0; end
                else begin ed = 1; edr = p_ack ? p_rd : 32'h0; end
                mb = 0;
            end else mcnt++;
        end else if (p_dreq || p_ireq) begin
            dwin = p_dreq && !(p_ireq && streak == MAXS);
            if (dwin) streak = p_ireq ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            else streak = 0;
            mb = dwin ? 2 : 1; mcnt = 0;
            e_we = dwin && p_dwe;
            e_addr = dwin ? p_daddr : p_iaddr;
            e_wd = p_dwd;
            e_ws = e_we ? p_dws : 4'h0;
        end
        chk("m_req", 32'(bus.m_req), 32'(mb != 0));
        if (mb != 0) begin
            chk("m_we", 32'(bus.m_we), 32'(e_we));
            chk("m_addr", bus.m_addr, e_addr);
            chk("m_wstrb", 32'(bus.m_wstrb), 32'(e_ws));
            if (e_we) chk("m_wdata", bus.m_wdata, e_wd);
        end
        chk("i_ready", 32'(bus.i_ready), 32'(ei));
        chk("d_ready", 32'(bus.d_ready), 32'(ed));
        chk("err", 32'(bus.err), 32'(ee));
        chk("i_rdata", bus.i_rdata, eir);
        chk("d_rdata", bus.d_rdata, edr);

        if (bus.i_ready) begin
            ord.push_back("I"); last_ir_tick = tickno; last_err_i = bus.err; last_irdata = bus.i_rdata;
        end
        if (bus.d_ready) begin
            ord.push_back("D"); last_dr_tick = tickno; last_err_d = bus.err;
        end
        if (bus.m_req) run++;
        else if (prev_mreq) begin last_len = run; run = 0; end

        // core: a completed request may be followed straight away by the next one
        if (i_act && bus.i_ready) i_act = 0;
        if (d_act && bus.d_ready) d_act = 0;
        if (!i_act && i_left > 0 && $urandom_range(99) < i_p) begin
            i_act = 1; i_a = $urandom() & 32'hFFFF_FFFC; i_left--;
        end
        if (!d_act && d_left > 0 && $urandom_range(99) < d_p) begin
            d_act = 1; d_we = 1'($urandom_range(1)); d_a = $urandom();
            d_wd = $urandom(); d_ws = 4'($urandom_range(15)); d_left--;
        end

        // memory: ack after a per-transaction delay; delays >= TMO never ack
        if (bus.m_req) begin
            if (!prev_mreq) begin
                mem_w = 0;
                if (fixed_delay >= 0) mem_delay = fixed_delay;
                else begin
                    dly = $urandom_range(7);
                    mem_delay = (dly < 2) ? 0 : (dly < 5) ? dly - 1 : (dly == 5) ? TMO - 1 : (dly == 6) ? TMO : 20;
                end
                m_rd = (fixed_delay >= 0) ? fix_rd : $urandom();
            end else mem_w++;
            m_ack = (mem_w == mem_delay);
        end else begin
            m_ack = spur && ($urandom_range(3) == 0);
            m_rd = $urandom();
        end
        prev_mreq = bus.m_req;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        for (k = 0; k < budget && (i_act || d_act || i_left > 0 || d_left > 0 || mb != 0); k++) tick();
        chk(tag, 32'(i_act || d_act || i_left > 0 || d_left > 0 || mb != 0), 32'd0);
    endtask

    initial begin
        tickno = 0; last_ir_tick = 0; last_dr_tick = 0; last_len = 0;
        last_err_i = 0; last_err_d = 0; last_irdata = 0;
        i_left = 0; d_left = 0; i_p = 0; d_p = 0; spur = 0;
        fixed_delay = 0; fix_rd = 32'h0000_0013; mem_delay = 0;
        model_reset();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_req", 32'(bus.m_req), 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single fetch, zero-wait memory
        i_act = 1; i_a = 32'h8000_0000; drive();
        last_ir_tick = -100;
        begin
            int t0;
            t0 = tickno;
            drain("t1_drain", 20);
            chk("t1_latency", 32'(last_ir_tick - t0), 32'd2);
        end
        chk("t1_rdata", last_irdata, 32'h0000_0013);
        chk("t1_err", 32'(last_err_i), 32'd0);

        // 2: simultaneous store and fetch, store first
        fix_rd = 32'h1234_5678; ord.delete();
        i_act = 1; i_a = 32'h8000_0004;
        d_act = 1; d_we = 1; d_a = 32'h100; d_wd = 32'hCAFE_F00D; d_ws = 4'hF; drive();
        drain("t2_drain", 30);
        chk("t2_count", 32'(ord.size()), 32'd2);
        if (ord.size() == 2) begin
            chk("t2_first", 32'(ord[0]), 32'("D"));
            chk("t2_second", 32'(ord[1]), 32'("I"));
        end

        // 3: continuous data traffic with a waiting fetch
        ord.delete();
        i_act = 1; i_a = 32'h8000_0008;
        d_act = 1; d_we = 0; d_a = 32'h200; d_ws = 4'hA; d_p = 100; d_left = 7; drive();
        drain("t3_drain", 100);
        d_p = 0;
        chk("t3_count", 32'(ord.size()), 32'd9);
        if (ord.size() >= 6) begin
            byte exp_ord [6];
            exp_ord = '{"D", "D", "D", "D", "I", "D"};
            for (int k = 0; k < 6; k++) chk("t3_order", 32'(ord[k]), 32'(exp_ord[k]));
        end

        // 4: memory never acknowledges
        fixed_delay = 100;
        d_act = 1; d_we = 0; d_a = 32'h300; drive();
        drain("t4_drain", 40);
        chk("t4_mreq_len", 32'(last_len), 32'(TMO));
        chk("t4_err", 32'(last_err_d), 32'd1);
        fixed_delay = 2; fix_rd = 32'hA5A5_0001;
        d_act = 1; d_we = 1; d_a = 32'h304; d_wd = 32'h0BAD_BEEF; d_ws = 4'h3; drive();
        drain("t4b_drain", 40);
        chk("t4b_err", 32'(last_err_d), 32'd0);

        // 5: asynchronous reset while a data transaction is outstanding
        fixed_delay = 100;
        d_act = 1; d_we = 1; d_a = 32'h400; d_wd = 32'h1; d_ws = 4'h1; drive();
        for (int k = 0; k < 10 && mb != 2; k++) tick();
        chk("t5_busy", 32'(bus.m_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_m_req", 32'(bus.m_req), 32'd0);
        chk("t5_rst_d_ready", 32'(bus.d_ready), 32'd0);
        chk("t5_rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fixed_delay = 1; fix_rd = 32'h0000_0073;
        i_act = 1; i_a = 32'h8000_0010; drive();
        drain("t5_drain", 20);
        chk("t5_err", 32'(last_err_i), 32'd0);
        chk("t5_rdata", last_irdata, 32'h0000_0073);

        // 6: spurious acks while idle
        ord.delete(); spur = 1;
        repeat (12) tick();
        chk("t6_no_ready", 32'(ord.size()), 32'd0);

        // randomized traffic, random delays including timeouts and ack-on-last-count
        fixed_delay = -1; i_p = 50; d_p = 50; i_left = 40; d_left = 40;
        drain("rand_drain", 5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
